fifo_1024x16_ctrl: RTL and testbench

FIFO_1024X16_CTRL -- requirements
Module: fifo_1024x16_ctrl

---
 rtl/fifo_1024x16_ctrl_pkg.sv | 10 +
 rtl/fifo_1024x16_ctrl_ram.sv | 20 ++
 rtl/fifo_1024x16_ctrl.sv | 79 +++++++
 tb/tb_fifo_1024x16_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_1024x16_ctrl_pkg.sv
// fifo_1024x16_ctrl_pkg: shared geometry constants and types for the 1024x16 FIFO controller
package fifo_1024x16_ctrl_pkg;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int CW = 11;
  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [CW-1:0] cnt_t;
endpackage

// File: rtl/fifo_1024x16_ctrl_ram.sv
// dualPort1024x16: 1024x16 RAM, one write port and one registered read port, contents not reset
module dualPort1024x16
  import fifo_1024x16_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t waddr,
  input  data_t wdata,
  input  logic  re,
  input  addr_t raddr,
  output data_t rdata
);
  data_t mem [DEPTH];
  data_t rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/fifo_1024x16_ctrl.sv
// fifo_1024x16_ctrl: 1024x16 FWFT FIFO controller around a registered-read RAM with a 2-entry output buffer
module fifo_1024x16_ctrl
  import fifo_1024x16_ctrl_pkg::*;
#(
  parameter int AF_THRESH = 1000,
  parameter int AE_THRESH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          almost_empty
);
  localparam cnt_t AF = CW'(AF_THRESH);
  localparam cnt_t AE = CW'(AE_THRESH);
  localparam cnt_t FULL = CW'(DEPTH);
  addr_t wptr_q, wptr_d, rptr_q, rptr_d;
  cnt_t count_q, count_d, unread;
  logic [1:0] occ_q, occ_d, occ_p;
  logic inflight_q, inflight_d;
  data_t buf0_q, buf0_d, buf1_q, buf1_d, ram_rdata;
  logic push, pop, rd;
  assign in_ready = count_q != FULL;
  assign out_valid = occ_q != 2'd0;
  assign out_data = out_valid ? buf0_q : '0;
  assign count = count_q;
  assign almost_full = count_q >= AF;
  assign almost_empty = count_q <= AE;
  // unread excludes words already buffered or in flight, so a read never targets the word being written
  always_comb begin
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready && !flush;
    unread = count_q - CW'(occ_q) - CW'(inflight_q);
    rd = !flush && unread != '0 && ({1'b0, occ_q} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
    occ_p = occ_q - {1'b0, pop};
    wptr_d = flush ? '0 : wptr_q + AW'(push);
    rptr_d = flush ? '0 : rptr_q + AW'(rd);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    inflight_d = rd;
    occ_d = flush ? '0 : occ_p + {1'b0, inflight_q};
    buf0_d = (inflight_q && occ_p == 2'd0) ? ram_rdata : pop ? buf1_q : buf0_q;
    buf1_d = (inflight_q && occ_p == 2'd1) ? ram_rdata : buf1_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      occ_q <= '0;
      inflight_q <= 1'b0;
      buf0_q <= '0;
      buf1_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      occ_q <= occ_d;
      inflight_q <= inflight_d;
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
    end
  end
  dualPort1024x16 u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (in_data),
    .re    (rd),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_fifo_1024x16_ctrl.sv
// tb_fifo_1024x16_ctrl: directed self-checking bench for fifo_1024x16_ctrl
module tb_fifo_1024x16_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_data;
  logic [10:0] count;
  logic almost_full, almost_empty;
  int compared = 0;
  int mismatched = 0;

  fifo_1024x16_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".out_data"}, 32'(out_data), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'd1);
    chk({tag, ".almost_full"}, 32'(almost_full), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk_idle("reset");
    step();
    step();
    chk_idle("in_reset_clocked");
    #3 rst_n = 1'b1;
    // single word latency into an empty FIFO
    in_valid = 1'b1;
    in_data = 16'hA5A5;
    step();
    in_valid = 1'b0;
    chk("a5.count_t", 32'(count), 32'd1);
    chk("a5.valid_t", 32'(out_valid), 32'd0);
    step();
    chk("a5.valid_t1", 32'(out_valid), 32'd0);
    step();
    chk("a5.valid_t2", 32'(out_valid), 32'd1);
    chk("a5.data_t2", 32'(out_data), 32'hA5A5);
    chk("a5.count_t2", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("a5.pop_count", 32'(count), 32'd0);
    chk("a5.pop_valid", 32'(out_valid), 32'd0);
    // fill to full with the consumer stalled
    in_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      in_data = 16'(i);
      step();
      chk("fill.count", 32'(count), 32'(i + 1));
      chk("fill.almost_full", 32'(almost_full), 32'(i + 1 >= 1000));
      chk("fill.almost_empty", 32'(almost_empty), 32'(i + 1 <= 16));
      chk("fill.in_ready", 32'(in_ready), 32'(i + 1 != 1024));
    end
    in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full.count", 32'(count), 32'd1024);
      chk("full.in_ready", 32'(in_ready), 32'd0);
    end
    chk("full.head", 32'(out_data), 32'h0);
    out_ready = 1'b1;
    step();
    chk("full.pop_refuses_push", 32'(count), 32'd1023);
    in_valid = 1'b0;
    for (int i = 1; i < 1024; i++) begin
      chk("drain.valid", 32'(out_valid), 32'd1);
      chk("drain.data", 32'(out_data), 32'(i));
      step();
    end
    chk("drain.count", 32'(count), 32'd0);
    chk("drain.valid_end", 32'(out_valid), 32'd0);
    // 3000-word stream through pointer wraps
    for (int c = 0; c < 3002; c++) begin
      in_valid = c < 3000;
      in_data = 16'(c);
      step();
      chk("stream.valid", 32'(out_valid), 32'(c >= 2));
      if (c >= 2) chk("stream.data", 32'(out_data), 32'(c - 2));
      chk("stream.count", 32'((c + 1 < 3000 ? c + 1 : 3000) - (c > 2 ? c - 2 : 0)), 32'(count));
    end
    step();
    out_ready = 1'b0;
    chk("stream.end_valid", 32'(out_valid), 32'd0);
    chk("stream.end_count", 32'(count), 32'd0);
    // steady push+pop at count 512
    in_valid = 1'b1;
    for (int i = 0; i < 512; i++) begin
      in_data = 16'(16'h1000 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("half.count", 32'(count), 32'd512);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_data = 16'(16'h1200 + k);
      chk("half.valid", 32'(out_valid), 32'd1);
      chk("half.data", 32'(out_data), 32'(16'h1000 + k));
      step();
      chk("half.count_hold", 32'(count), 32'd512);
    end
    in_valid = 1'b0;
    for (int k = 100; k < 612; k++) begin
      chk("half.drain", 32'(out_data), 32'(16'h1000 + k));
      step();
    end
    out_ready = 1'b0;
    chk("half.end_count", 32'(count), 32'd0);
    chk("half.end_valid", 32'(out_valid), 32'd0);
    // flush with a RAM read in flight
    in_valid = 1'b1;
    in_data = 16'h5555;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h7777;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.valid", 32'(out_valid), 32'd0);
    chk("flush.in_ready", 32'(in_ready), 32'd1);
    step();
    chk("flush.discard", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("flush.next_valid", 32'(out_valid), 32'd1);
    chk("flush.next_data", 32'(out_data), 32'h1234);
    chk("flush.next_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("flush.pop_count", 32'(count), 32'd0);
    // asynchronous reset mid-burst
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'(16'h2000 + i);
      step();
    end
    step();
    chk("burst.count", 32'(count), 32'd6);
    chk("burst.head", 32'(out_data), 32'h2000);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    in_valid = 1'b0;
    step();
    chk_idle("async_reset_held");
    #2 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    chk("resume.count", 32'(count), 32'd1);
    step();
    step();
    chk("resume.valid", 32'(out_valid), 32'd1);
    chk("resume.data", 32'(out_data), 32'hBEEF);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("resume.pop_count", 32'(count), 32'd0);
    chk("resume.almost_empty", 32'(almost_empty), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
